fp32_to_fixed: RTL and testbench

- Sequential IEEE-754 single-precision to signed two's-complement fixed-point converter (Q format, FRAC_BITS fractional bits).
- It is the unpacking counterpart of the FP32 adder/rounder datapath: it decodes FP results (e.g. similarity scores, embedding elements) into fixed-point for the integer threshold/compare logic.
- Uses a valid/ready handshake on both sides and an iterative 1-bit-per-cycle shifter.
- Uses the same 2-bit round_mode encoding as the FP adder.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fixed_round_sat.sv | 71 +++++++
 rtl/fp32_to_fixed.sv | 202 ++++++++++++++++++++
 tb/tb_fp32_to_fixed.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the FP datapath blocks.
// Holds the FP32 field layout, exponent constants, the 2-bit rounding-mode
// encoding shared with the FP adder, and the converter FSM state type.
package fp_pkg;

    // FP32 field layout
    localparam int unsigned SIGN_POS = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;

    // Exponent constants
    localparam int              EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'd255;

    // Rounding modes (same encoding as the FP adder)
    localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
    localparam logic [1:0] RM_RTZ = 2'b01;  // toward zero
    localparam logic [1:0] RM_RUP = 2'b10;  // toward +inf
    localparam logic [1:0] RM_RDN = 2'b11;  // toward -inf

    // Converter FSM states
    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        ROUND,
        OUT
    } state_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational round-and-saturate stage for the FP32 to fixed converter.
// Ports:
//   mag        in  OUT_W+1  unsigned magnitude, already aligned to the output LSB
//   sign       in  1        sign of the value
//   guard      in  1        first bit below the LSB
//   round_bit  in  1        second bit below the LSB
//   sticky     in  1        OR of all remaining lower bits
//   round_mode in  2        rounding mode (fp_pkg RM_* encoding)
//   out_data   out OUT_W    signed two's-complement result (saturated)
//   overflow   out 1        magnitude did not fit and was saturated
//   inexact    out 1        any discarded bit was set
module fixed_round_sat
    import fp_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic [OUT_W:0]   mag,
    input  logic             sign,
    input  logic             guard,
    input  logic             round_bit,
    input  logic             sticky,
    input  logic [1:0]       round_mode,
    output logic [OUT_W-1:0] out_data,
    output logic             overflow,
    output logic             inexact
);

    localparam int unsigned MAG_W = OUT_W + 1;

    // Largest representable magnitudes for each sign
    localparam logic [MAG_W-1:0] POS_LIMIT = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [MAG_W-1:0] NEG_LIMIT = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_POS   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG   = {1'b1, {(OUT_W-1){1'b0}}};

    logic             inc;
    logic [MAG_W-1:0] sum;
    logic [MAG_W-1:0] neg_sum;

    // Rounding increment decision
    always_comb begin
        inc     = 1'b0;
        inexact = guard | round_bit | sticky;
        case (round_mode)
            RM_RNE:  inc = guard & (round_bit | sticky | mag[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact & ~sign;
            RM_RDN:  inc = inexact & sign;
            default: inc = 1'b0;
        endcase
    end

    // Apply increment, then saturate or negate
    always_comb begin
        sum      = mag + MAG_W'(inc);
        neg_sum  = -sum;
        overflow = 1'b0;
        out_data = sum[OUT_W-1:0];
        if (!sign && (sum > POS_LIMIT)) begin
            overflow = 1'b1;
            out_data = SAT_POS;
        end else if (sign && (sum > NEG_LIMIT)) begin
            overflow = 1'b1;
            out_data = SAT_NEG;
        end else if (sign) begin
            // magnitude 2^(OUT_W-1) negates onto itself, giving the most negative code
            out_data = neg_sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fp32_to_fixed.sv
// Sequential IEEE-754 single-precision to signed Q-format fixed-point converter.
// Aligns the mantissa with a 1-bit-per-cycle shifter, then rounds and saturates.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    in   FP32 word valid
//   in_ready    out  converter idle and able to accept a word
//   in_data     in   FP32 operand
//   round_mode  in   rounding mode, sampled at accept
//   out_valid   out  result valid, held until out_ready
//   out_ready   in   downstream accepts the result
//   out_data    out  signed fixed-point result with FRAC_BITS fractional bits
//   out_flags   out  {nan, overflow, inexact}
module fp32_to_fixed
    import fp_pkg::*;
#(
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_flags
);

    localparam int unsigned MAG_W = OUT_W + 1;
    localparam int unsigned CNT_W = 5;

    // sh = e - (bias + mantissa width) + FRAC_BITS
    localparam logic signed [9:0] SH_OFS =
        10'(int'(FRAC_BITS) - EXP_BIAS - int'(MANT_W));
    // Leading one would land at or above the sign bit
    localparam logic signed [9:0] SH_SAT   = 10'(int'(OUT_W) - 25);
    // Leading one lands exactly on the sign bit: only -2^(OUT_W-1) fits
    localparam logic signed [9:0] SH_EXACT = 10'(int'(OUT_W) - 24);
    // Below this every mantissa bit ends up in the sticky bit
    localparam logic signed [9:0] SH_MIN   = -10'sd26;

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    state_t             state;
    logic [31:0]        data_q;
    logic [1:0]         rm_q;
    logic               sign_q;
    logic [MAG_W-1:0]   mag_q;
    logic               guard_q;
    logic               round_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               left_q;

    logic                   sign_c;
    logic [EXP_W-1:0]       exp_c;
    logic [MANT_W-1:0]      mant_c;
    logic signed [9:0]      sh_c;
    logic signed [9:0]      sh_abs_c;
    logic [OUT_W-1:0]       rs_data_c;
    logic                   rs_ovf_c;
    logic                   rs_inexact_c;

    // Field decode and shift amount of the captured word
    always_comb begin
        sign_c   = data_q[SIGN_POS];
        exp_c    = data_q[EXP_MSB:EXP_LSB];
        mant_c   = data_q[MANT_MSB:0];
        sh_c     = $signed({2'b00, exp_c}) + SH_OFS;
        sh_abs_c = sh_c[9] ? -sh_c : sh_c;
    end

    fixed_round_sat #(
        .OUT_W (OUT_W)
    ) u_round_sat (
        .mag        (mag_q),
        .sign       (sign_q),
        .guard      (guard_q),
        .round_bit  (round_q),
        .sticky     (sticky_q),
        .round_mode (rm_q),
        .out_data   (rs_data_c),
        .overflow   (rs_ovf_c),
        .inexact    (rs_inexact_c)
    );

    // Converter FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
            data_q    <= '0;
            rm_q      <= RM_RNE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        rm_q     <= round_mode;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end

                UNPACK: begin
                    sign_q   <= sign_c;
                    guard_q  <= 1'b0;
                    round_q  <= 1'b0;
                    sticky_q <= 1'b0;
                    if (exp_c == EXP_MAX) begin
                        // NaN yields zero; infinity saturates by sign
                        if (mant_c != '0) begin
                            out_data  <= '0;
                            out_flags <= 3'b100;
                        end else begin
                            out_data  <= sign_c ? SAT_NEG : SAT_POS;
                            out_flags <= 3'b010;
                        end
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (exp_c == '0) begin
                        // zero and denormals flush to zero
                        out_data  <= '0;
                        out_flags <= {2'b00, mant_c != '0};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if ((sh_c == SH_EXACT) && (mant_c == '0) && sign_c) begin
                        out_data  <= SAT_NEG;
                        out_flags <= 3'b000;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (sh_c > SH_SAT) begin
                        out_data  <= sign_c ? SAT_NEG : SAT_POS;
                        out_flags <= 3'b010;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (sh_c < SH_MIN) begin
                        // too small to reach the guard bit: only sticky survives
                        mag_q    <= '0;
                        sticky_q <= 1'b1;
                        state    <= ROUND;
                    end else begin
                        mag_q  <= MAG_W'({1'b1, mant_c});
                        cnt_q  <= CNT_W'(sh_abs_c);
                        left_q <= ~sh_c[9];
                        state  <= (sh_c == '0) ? ROUND : SHIFT;
                    end
                end

                SHIFT: begin
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        sticky_q <= sticky_q | round_q;
                        round_q  <= guard_q;
                        guard_q  <= mag_q[0];
                        mag_q    <= mag_q >> 1;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    out_data  <= rs_data_c;
                    out_flags <= {1'b0, rs_ovf_c, rs_inexact_c};
                    out_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Self-checking bench for fp32_to_fixed (OUT_W=32, FRAC_BITS=16).
// An exact-arithmetic model supplies expected results; a compare process
// checks every valid output cycle; directed vectors pin the model.
module tb_fp32_to_fixed;

    localparam int FRAC = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int          checks;
    int          failures;
    logic [31:0] exp_data;
    logic [2:0]  exp_flags;

    fp32_to_fixed #(
        .OUT_W     (32),
        .FRAC_BITS (FRAC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Exact value = (-1)^s * 1.m * 2^(e-127), scaled by 2^FRAC, then rounded.
    // lat counts the accept cycle as 1; 0 means not checked.
    function automatic void model(input logic [31:0] w, input logic [1:0] rm,
                                  output logic [31:0] d, output logic [2:0] f,
                                  output int lat);
        logic   s;
        int     e;
        int     k;
        int     sh;
        longint num;
        longint q;
        longint rem;
        longint half;
        longint val;
        bit     inexact;
        bit     inc;
        bit     ovf;
        s       = w[31];
        e       = int'(w[30:23]);
        num     = longint'({1'b1, w[22:0]});
        d       = 32'h0;
        f       = 3'b000;
        lat     = 2;
        inexact = 1'b0;
        inc     = 1'b0;
        ovf     = 1'b0;
        if (e == 255) begin
            if (w[22:0] != 23'h0) begin
                f = 3'b100;
            end else begin
                d = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                f = 3'b010;
            end
            return;
        end
        if (e == 0) begin
            f = {2'b00, w[22:0] != 23'h0};
            return;
        end
        k = e - 150 + FRAC;
        if (k >= 0) begin
            val = (k > 39) ? 64'sh4000_0000_0000_0000 : (num <<< k);
            lat = (val >= 64'sd2147483648) ? 2 : 3 + k;
        end else begin
            sh  = -k;
            lat = (sh > 26) ? 0 : 3 + sh;
            if (sh > 40) begin
                q    = 0;
                rem  = 1;
                half = 2;
            end else begin
                q    = num >>> sh;
                rem  = num - (q <<< sh);
                half = 64'sd1 <<< (sh - 1);
            end
            inexact = (rem != 0);
            case (rm)
                2'b00:   inc = (rem > half) || ((rem == half) && q[0]);
                2'b01:   inc = 1'b0;
                2'b10:   inc = inexact && !s;
                default: inc = inexact && s;
            endcase
            val = q + (inc ? 64'sd1 : 64'sd0);
        end
        if (!s && (val > 64'sd2147483647)) begin
            d   = 32'h7FFF_FFFF;
            ovf = 1'b1;
        end else if (s && (val > 64'sd2147483648)) begin
            d   = 32'h8000_0000;
            ovf = 1'b1;
        end else begin
            d = s ? 32'(-val) : 32'(val);
        end
        f = {1'b0, ovf, inexact};
    endfunction

    // Every valid output cycle must match the model and hold off new input
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("out_data", 64'(out_data), 64'(exp_data));
            check("out_flags", 64'(out_flags), 64'(exp_flags));
            check("in_ready_busy", 64'(in_ready), 64'd0);
        end
    end

    task automatic wait_out_valid(input int lat_exp);
        int lat;
        bit ok;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("out_valid_timeout", 64'(ok), 64'd1);
        if (ok && (lat_exp != 0)) check("latency", 64'(lat), 64'(lat_exp));
    endtask

    task automatic wait_consumed();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("consume_timeout", 64'(ok), 64'd1);
    endtask

    task automatic convert(input logic [31:0] w, input logic [1:0] rm);
        int lat_exp;
        bit ok;
        model(w, rm, exp_data, exp_flags, lat_exp);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("in_ready_timeout", 64'(ok), 64'd1);
        in_valid   = 1'b1;
        in_data    = w;
        round_mode = rm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out_valid(lat_exp);
        wait_consumed();
    endtask

    // Pin the model against hand-computed values, then run the DUT
    task automatic run_vec(input logic [31:0] w, input logic [1:0] rm,
                           input logic [31:0] lit_d, input logic [2:0] lit_f,
                           input int lit_lat);
        logic [31:0] md;
        logic [2:0]  mf;
        int          ml;
        model(w, rm, md, mf, ml);
        check("model_data", 64'(md), 64'(lit_d));
        check("model_flags", 64'(mf), 64'(lit_f));
        if (lit_lat != 0) check("model_latency", 64'(ml), 64'(lit_lat));
        convert(w, rm);
    endtask

    initial begin
        int lat_b;
        checks     = 0;
        failures   = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        round_mode = 2'b00;
        out_ready  = 1'b1;
        exp_data   = 32'h0;
        exp_flags  = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal values
        run_vec(32'h3F80_0000, 2'b00, 32'h0001_0000, 3'b000, 10);
        run_vec(32'hC020_0000, 2'b00, 32'hFFFD_8000, 3'b000, 9);
        run_vec(32'h3FC0_0000, 2'b00, 32'h0001_8000, 3'b000, 10);
        run_vec(32'h46FF_FFFE, 2'b00, 32'h7FFF_FF00, 3'b000, 10);
        // Half-LSB tie in each direction
        run_vec(32'h3700_0000, 2'b00, 32'h0000_0000, 3'b001, 27);
        run_vec(32'h3700_0000, 2'b10, 32'h0000_0001, 3'b001, 27);
        run_vec(32'h3700_0000, 2'b01, 32'h0000_0000, 3'b001, 27);
        run_vec(32'hB700_0000, 2'b11, 32'hFFFF_FFFF, 3'b001, 27);
        run_vec(32'h3740_0000, 2'b00, 32'h0000_0001, 3'b001, 0);
        run_vec(32'h37C0_0000, 2'b00, 32'h0000_0002, 3'b001, 26);
        // Collapsed to sticky
        run_vec(32'h3380_0000, 2'b10, 32'h0000_0001, 3'b001, 0);
        run_vec(32'h3380_0000, 2'b00, 32'h0000_0000, 3'b001, 0);
        // Saturation and specials
        run_vec(32'h4700_0000, 2'b00, 32'h7FFF_FFFF, 3'b010, 2);
        run_vec(32'hC700_0000, 2'b00, 32'h8000_0000, 3'b000, 2);
        run_vec(32'hC780_0000, 2'b00, 32'h8000_0000, 3'b010, 2);
        run_vec(32'h7F80_0000, 2'b00, 32'h7FFF_FFFF, 3'b010, 2);
        run_vec(32'hFF80_0000, 2'b00, 32'h8000_0000, 3'b010, 2);
        run_vec(32'h7FC0_0000, 2'b00, 32'h0000_0000, 3'b100, 2);
        run_vec(32'h0000_0001, 2'b10, 32'h0000_0000, 3'b001, 2);
        run_vec(32'h8000_0000, 2'b00, 32'h0000_0000, 3'b000, 2);

        // Backpressure: result held, second word waits for in_ready
        out_ready = 1'b0;
        model(32'h3FC0_0000, 2'b00, exp_data, exp_flags, lat_b);
        in_valid   = 1'b1;
        in_data    = 32'h3FC0_0000;
        round_mode = 2'b00;
        @(posedge clk);
        #1;
        in_data    = 32'hC020_0000;
        wait_out_valid(lat_b);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        model(32'hC020_0000, 2'b00, exp_data, exp_flags, lat_b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second_accept", 64'(in_ready), 64'd0);
        wait_out_valid(lat_b);
        wait_consumed();

        // Asynchronous reset in the middle of a shift
        model(32'h3F80_0000, 2'b00, exp_data, exp_flags, lat_b);
        in_valid   = 1'b1;
        in_data    = 32'h3F80_0000;
        round_mode = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(32'h3F80_0000, 2'b00, 32'h0001_0000, 3'b000, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
